// File: rtl/log_ram_ctrl_if.sv
// Violation-log RAM controller bus bundle:
// logger strobes, readout handshake, RAM port and status.
interface log_ram_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 37
);
  logic          log_we;
  logic [DW-1:0] log_data;
  logic          clr_req;
  logic          clr_busy;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   entry_cnt;
  logic          overflow;
  logic [15:0]   dropped_cnt;

  modport master (
    output log_we, log_data, clr_req,
    output rd_req, rd_addr, ram_rdata,
    input  clr_busy, rd_ack, rd_data,
    input  ram_en, ram_we, ram_addr,
    input  ram_wdata, wr_ptr, entry_cnt,
    input  overflow, dropped_cnt
  );

  modport slave (
    input  log_we, log_data, clr_req,
    input  rd_req, rd_addr, ram_rdata,
    output clr_busy, rd_ack, rd_data,
    output ram_en, ram_we, ram_addr,
    output ram_wdata, wr_ptr, entry_cnt,
    output overflow, dropped_cnt
  );
endinterface

// File: rtl/log_ram_ctrl.sv
// Single-port violation-log RAM owner: logger writes,
// readout arbitration, circular pointer and clear sweep.
module log_ram_ctrl #(
  parameter int AW = 8,
  parameter int DW = 37
) (
  input  logic         clk,
  input  logic         reset,
  log_ram_ctrl_if.slave bus
);

  localparam logic [AW:0] FULL =
    {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    ACK,
    CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;

  logic accept_clr;
  logic do_drop;
  logic do_wr;
  logic clr_last;

  // Clear owns the port from acceptance until busy falls
  assign accept_clr = (state_q == IDLE) && pend_q;
  assign do_drop = bus.log_we &&
    (accept_clr || state_q == CLEAR);
  assign do_wr = bus.log_we && !do_drop;
  assign clr_last = (state_q == CLEAR) &&
    (addr_q == LAST);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q |
      (bus.clr_req && state_q != CLEAR);
    busy_d  = busy_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;

    if (do_drop && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;

    if (do_wr) begin
      en_d    = 1'b1;
      we_d    = 1'b1;
      addr_d  = ptr_q;
      wdata_d = bus.log_data;
      ptr_d   = ptr_q + 1'b1;
      if (cnt_q != FULL)
        cnt_d = cnt_q + 1'b1;
      else
        ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
        end else if (bus.rd_req &&
                     !bus.log_we) begin
          state_d = RD1;
          en_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.rd_addr;
        end
      end
      RD1: state_d = RD2;
      RD2: begin
        state_d = ACK;
        rdata_d = bus.ram_rdata;
        ack_d   = 1'b1;
      end
      ACK: state_d = IDLE;
      CLEAR: begin
        if (clr_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          en_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = addr_q + 1'b1;
          wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.clr_busy    = busy_q;
  assign bus.rd_ack      = ack_q;
  assign bus.rd_data     = rdata_q;
  assign bus.ram_en      = en_q;
  assign bus.ram_we      = we_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.wr_ptr      = ptr_q;
  assign bus.entry_cnt   = cnt_q;
  assign bus.overflow    = ovf_q;
  assign bus.dropped_cnt = drop_q;

endmodule

// File: tb/tb_log_ram_ctrl.sv
// Bench for log_ram_ctrl at AW=3: RAM-op and readout
// scoreboards, a wrap table, and clear/reset sequences.
module tb_log_ram_ctrl;
  localparam int AW = 3;
  localparam int DW = 37;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
    logic [AW-1:0] ptr;
    logic [AW:0]   cnt;
    logic          ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  log_ram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  log_ram_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail = 0;
  logic mon_on = 1'b1;
  op_t exp_ops[$];
  logic [DW-1:0] exp_rd[$];
  op_t mon_e;
  logic [DW-1:0] mon_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] mptr = '0;
  vec_t vecs [10];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t mkop(input logic we,
                               input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    op_t o;
    o.we = we;
    o.addr = a;
    o.wdata = d;
    return o;
  endfunction

  task automatic wr(input logic [DW-1:0] d);
    bus.log_we = 1'b1;
    bus.log_data = d;
    exp_ops.push_back(mkop(1'b1, mptr, d));
    mptr = mptr + 1'b1;
    tick();
  endtask

  // Behavioural RAM: read data appears the cycle after
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we)
        mem[bus.ram_addr] <= bus.ram_wdata;
      else
        bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (bus.ram_en) begin
        if (exp_ops.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ram_op_extra: got we=%0b addr=%0h, required no op",
                   bus.ram_we, bus.ram_addr);
        end else begin
          mon_e = exp_ops.pop_front();
          check("ram_we", 64'(bus.ram_we), 64'(mon_e.we));
          check("ram_addr", 64'(bus.ram_addr),
                64'(mon_e.addr));
          if (mon_e.we)
            check("ram_wdata", 64'(bus.ram_wdata),
                  64'(mon_e.wdata));
        end
      end
      if (bus.rd_ack) begin
        if (exp_rd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_ack_extra: got ack data=%0h, required none",
                   bus.rd_data);
        end else begin
          mon_d = exp_rd.pop_front();
          check("rd_data", 64'(bus.rd_data), 64'(mon_d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int busy_cycles;
    int en_seen;
    logic [DW-1:0] acc;

    vecs[0] = '{1'b1, 37'h100, 3'd1, 4'd1, 1'b0};
    vecs[1] = '{1'b1, 37'h101, 3'd2, 4'd2, 1'b0};
    vecs[2] = '{1'b1, 37'h102, 3'd3, 4'd3, 1'b0};
    vecs[3] = '{1'b1, 37'h103, 3'd4, 4'd4, 1'b0};
    vecs[4] = '{1'b1, 37'h104, 3'd5, 4'd5, 1'b0};
    vecs[5] = '{1'b1, 37'h105, 3'd6, 4'd6, 1'b0};
    vecs[6] = '{1'b1, 37'h106, 3'd7, 4'd7, 1'b0};
    vecs[7] = '{1'b1, 37'h107, 3'd0, 4'd8, 1'b0};
    vecs[8] = '{1'b1, 37'h108, 3'd1, 4'd8, 1'b1};
    vecs[9] = '{1'b1, 37'h109, 3'd2, 4'd8, 1'b1};

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus.log_we = 1'b0;
    bus.log_data = '0;
    bus.clr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;

    tick();
    tick();
    check("rst_wr_ptr", 64'(bus.wr_ptr), 64'(0));
    check("rst_cnt", 64'(bus.entry_cnt), 64'(0));
    check("rst_ovf", 64'(bus.overflow), 64'(0));
    check("rst_drop", 64'(bus.dropped_cnt), 64'(0));
    check("rst_busy", 64'(bus.clr_busy), 64'(0));
    check("rst_ack", 64'(bus.rd_ack), 64'(0));
    check("rst_ram_en", 64'(bus.ram_en), 64'(0));
    reset = 1'b0;
    tick();

    // wrap table
    for (int i = 0; i < 10; i++) begin
      bus.log_we = vecs[i].we;
      bus.log_data = vecs[i].data;
      if (vecs[i].we) begin
        exp_ops.push_back(mkop(1'b1, mptr, vecs[i].data));
        mptr = mptr + 1'b1;
      end
      tick();
      check($sformatf("tbl%0d_ptr", i),
            64'(bus.wr_ptr), 64'(vecs[i].ptr));
      check($sformatf("tbl%0d_cnt", i),
            64'(bus.entry_cnt), 64'(vecs[i].cnt));
      check($sformatf("tbl%0d_ovf", i),
            64'(bus.overflow), 64'(vecs[i].ovf));
    end
    bus.log_we = 1'b0;
    tick();
    check("wrap_mem0", 64'(mem[0]), 64'h108);
    check("wrap_mem1", 64'(mem[1]), 64'h109);

    reset = 1'b1;
    mptr = '0;
    tick();
    reset = 1'b0;
    check("rst2_ovf", 64'(bus.overflow), 64'(0));
    check("rst2_cnt", 64'(bus.entry_cnt), 64'(0));
    tick();

    // three writes from reset
    wr(37'd1);
    wr(37'd2);
    wr(37'd3);
    bus.log_we = 1'b0;
    check("w3_ptr", 64'(bus.wr_ptr), 64'(3));
    check("w3_cnt", 64'(bus.entry_cnt), 64'(3));
    check("w3_ovf", 64'(bus.overflow), 64'(0));
    tick();

    // read latency
    wr(37'hA);
    wr(37'hB);
    wr(37'h15);
    bus.log_we = 1'b0;
    tick();
    bus.rd_req = 1'b1;
    bus.rd_addr = 3'd5;
    exp_ops.push_back(mkop(1'b0, 3'd5, '0));
    exp_rd.push_back(37'h15);
    tick();
    check("rd_t1_en", 64'(bus.ram_en), 64'(1));
    check("rd_t1_we", 64'(bus.ram_we), 64'(0));
    check("rd_t1_addr", 64'(bus.ram_addr), 64'(5));
    tick();
    check("rd_t2_ack", 64'(bus.rd_ack), 64'(0));
    tick();
    check("rd_t3_ack", 64'(bus.rd_ack), 64'(1));
    check("rd_t3_data", 64'(bus.rd_data), 64'h15);
    bus.rd_req = 1'b0;
    tick();
    check("rd_t4_ack", 64'(bus.rd_ack), 64'(0));
    check("rd_t4_hold", 64'(bus.rd_data), 64'h15);

    // read starved by writes
    bus.rd_req = 1'b1;
    bus.rd_addr = 3'd2;
    for (int i = 0; i < 4; i++) begin
      exp_ops.push_back(mkop(1'b1, mptr, 37'h200 + 37'(i)));
      mptr = mptr + 1'b1;
    end
    exp_ops.push_back(mkop(1'b0, 3'd2, '0));
    exp_rd.push_back(37'd3);
    for (int i = 0; i < 4; i++) begin
      bus.log_we = 1'b1;
      bus.log_data = 37'h200 + 37'(i);
      tick();
      check($sformatf("starve%0d_we", i),
            64'(bus.ram_we), 64'(1));
    end
    bus.log_we = 1'b0;
    k = 0;
    while (!bus.rd_ack && k < 10) begin
      tick();
      k++;
    end
    check("starve_ack", 64'(bus.rd_ack), 64'(1));
    check("starve_lat", 64'(k), 64'(3));
    bus.rd_req = 1'b0;
    check("starve_ptr", 64'(bus.wr_ptr), 64'(2));
    check("starve_cnt", 64'(bus.entry_cnt), 64'(8));
    check("starve_ovf", 64'(bus.overflow), 64'(1));
    tick();

    // clear requested during a read
    bus.rd_req = 1'b1;
    bus.rd_addr = 3'd4;
    exp_ops.push_back(mkop(1'b0, 3'd4, '0));
    exp_rd.push_back(37'hB);
    for (int i = 0; i < DEPTH; i++)
      exp_ops.push_back(mkop(1'b1, AW'(i), '0));
    tick();
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    tick();
    check("clr_ack_first", 64'(bus.rd_ack), 64'(1));
    check("clr_busy_at_ack", 64'(bus.clr_busy), 64'(0));
    bus.rd_req = 1'b0;
    k = 0;
    while (!bus.clr_busy && k < 10) begin
      tick();
      k++;
    end
    check("clr_start", 64'(bus.clr_busy), 64'(1));
    busy_cycles = 0;
    while (bus.clr_busy && busy_cycles < 4 * DEPTH) begin
      busy_cycles++;
      bus.log_we = (busy_cycles <= 3);
      bus.log_data = 37'h3F;
      tick();
    end
    bus.log_we = 1'b0;
    mptr = '0;
    check("clr_len", 64'(busy_cycles), 64'(DEPTH));
    check("clr_drop", 64'(bus.dropped_cnt), 64'(3));
    check("clr_ptr", 64'(bus.wr_ptr), 64'(0));
    check("clr_cnt", 64'(bus.entry_cnt), 64'(0));
    check("clr_ovf", 64'(bus.overflow), 64'(0));
    tick();
    acc = '0;
    for (int i = 0; i < DEPTH; i++) acc = acc | mem[i];
    check("clr_mem_zero", 64'(acc), 64'(0));

    // reset in the middle of a sweep
    wr(37'h51);
    wr(37'h52);
    bus.log_we = 1'b0;
    tick();
    mon_on = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    k = 0;
    while (!bus.clr_busy && k < 10) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("mid_busy", 64'(bus.clr_busy), 64'(1));
    check("mid_ptr", 64'(bus.wr_ptr), 64'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mptr = '0;
    check("mr_busy", 64'(bus.clr_busy), 64'(0));
    check("mr_ptr", 64'(bus.wr_ptr), 64'(0));
    check("mr_cnt", 64'(bus.entry_cnt), 64'(0));
    check("mr_drop", 64'(bus.dropped_cnt), 64'(0));
    check("mr_en", 64'(bus.ram_en), 64'(0));
    en_seen = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      tick();
      if (bus.ram_en) en_seen++;
    end
    check("mr_no_ops", 64'(en_seen), 64'(0));
    mon_on = 1'b1;
    tick();

    check("ops_left", 64'(exp_ops.size()), 64'(0));
    check("rd_left", 64'(exp_rd.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
